jtsdram_sched: RTL and testbench

Test scheduler and port arbiter for the JTSDRAM checker. It runs a configurable number of read-check passes over four `jtsdram_bank` checkers, one per SDRAM bank, and shares the single SDRAM controller read port between them with round-robin arbitration. It also collects their pass/fail results. It sits between the four bank checkers and the SDRAM controller, under the top-level test FSM.

---
 rtl/jtsdram_pkg.sv | 12 +
 rtl/jtsdram_sched_if.sv | 30 +++
 rtl/jtsdram_rrarb.sv | 19 +
 rtl/jtsdram_sched.sv | 112 +++++++++++
 tb/tb_jtsdram_sched.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the JTSDRAM test scheduler slice.
package jtsdram_pkg;
   localparam int NBANK  = 4;
   localparam int AW_DEF = 22;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_NEXT  = 2'd3
   } state_t;
endpackage

// File: rtl/jtsdram_sched_if.sv
// Bank-checker and SDRAM read-port signals seen by the scheduler.
interface jtsdram_sched_if #(
   parameter int AW = jtsdram_pkg::AW_DEF
);
   import jtsdram_pkg::*;

   logic [NBANK-1:0]    bank_rd;
   logic [NBANK*AW-1:0] bank_addr;
   logic [NBANK-1:0]    bank_done;
   logic [NBANK-1:0]    bank_bad;
   logic [NBANK-1:0]    bank_ack;
   logic [NBANK-1:0]    bank_rdy;
   logic                sdram_rd;
   logic [1:0]          sdram_ba;
   logic [AW-1:0]       sdram_addr;
   logic                sdram_ack;
   logic                sdram_rdy;

   // sdram_rd is held from grant until sdram_ack or sdram_rdy; sdram_rdy closes the
   // transaction. bank_ack/bank_rdy repeat those strobes to the owning bank only.
   modport master (
      input  bank_rd, bank_addr, bank_done, bank_bad, sdram_ack, sdram_rdy,
      output bank_ack, bank_rdy, sdram_rd, sdram_ba, sdram_addr
   );

   modport slave (
      output bank_rd, bank_addr, bank_done, bank_bad, sdram_ack, sdram_rdy,
      input  bank_ack, bank_rdy, sdram_rd, sdram_ba, sdram_addr
   );
endinterface

// File: rtl/jtsdram_rrarb.sv
// Combinational 4-way round-robin pick starting after the last winner.
module jtsdram_rrarb
   import jtsdram_pkg::*;
(
   input  logic [NBANK-1:0] i_req,
   input  logic [1:0]       i_last,
   output logic [1:0]       o_win,
   output logic             o_any
);
   always_comb begin
      o_win = i_last;
      // Walk from the farthest slot back to the nearest so the nearest requester wins.
      for (int k = NBANK; k >= 1; k--) begin
         if (i_req[i_last + 2'(k)]) o_win = i_last + 2'(k);
      end
   end

   assign o_any = |i_req;
endmodule

// File: rtl/jtsdram_sched.sv
// Pass sequencer and round-robin SDRAM read-port arbiter for the four bank checkers.
module jtsdram_sched
   import jtsdram_pkg::*;
#(
   parameter int PASSES = 4,
   parameter int AW     = AW_DEF
) (
   input  logic             rst,
   input  logic             clk,
   input  logic             go,
   output logic             busy,
   output logic             bank_start,
   output logic [7:0]       pass_cnt,
   output logic             fail,
   output logic [NBANK-1:0] fail_bank,
   output state_t           o_dbg_state,
   jtsdram_sched_if.master  bus
);
   state_t           r_state, w_next;
   logic [1:0]       r_owner, r_last, w_win;
   logic             r_inflight, r_rd, w_any, w_grant;
   logic [1:0]       r_ba;
   logic [AW-1:0]    r_addr;
   logic [7:0]       r_pass_cnt;
   logic             r_fail;
   logic [NBANK-1:0] r_fail_bank;

   jtsdram_rrarb u_arb (
      .i_req  (bus.bank_rd),
      .i_last (r_last),
      .o_win  (w_win),
      .o_any  (w_any)
   );

   assign w_grant = (r_state == ST_RUN) && !r_inflight && w_any;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      busy       = 1'b1;
      bank_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (go) w_next = ST_START;
         end
         ST_START: begin
            bank_start = 1'b1;
            w_next     = ST_RUN;
         end
         ST_RUN: begin
            if ((&bus.bank_done) && !r_inflight) w_next = ST_NEXT;
         end
         ST_NEXT: begin
            w_next = (r_pass_cnt + 8'd1 == 8'(PASSES)) ? ST_IDLE : ST_START;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pass_cnt  <= 8'd0;
         r_fail      <= 1'b0;
         r_fail_bank <= '0;
      end else if (r_state == ST_IDLE && go) begin
         r_pass_cnt  <= 8'd0;
         r_fail      <= 1'b0;
         r_fail_bank <= '0;
      end else if (r_state == ST_NEXT) begin
         r_pass_cnt  <= r_pass_cnt + 8'd1;
         r_fail_bank <= bus.bank_bad;
         r_fail      <= r_fail | (|bus.bank_bad);
      end
   end

   // A ready without an ack still releases the port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner    <= 2'd0;
         r_last     <= 2'd3;
         r_inflight <= 1'b0;
         r_rd       <= 1'b0;
         r_ba       <= 2'd0;
         r_addr     <= '0;
      end else if (w_grant) begin
         r_owner    <= w_win;
         r_last     <= w_win;
         r_inflight <= 1'b1;
         r_rd       <= 1'b1;
         r_ba       <= w_win;
         r_addr     <= bus.bank_addr[32'(w_win)*AW +: AW];
      end else if (r_inflight) begin
         if (bus.sdram_ack || bus.sdram_rdy) r_rd <= 1'b0;
         if (bus.sdram_rdy) r_inflight <= 1'b0;
      end
   end

   assign bus.bank_ack   = r_inflight ? ({3'b000, bus.sdram_ack} << r_owner) : '0;
   assign bus.bank_rdy   = r_inflight ? ({3'b000, bus.sdram_rdy} << r_owner) : '0;
   assign bus.sdram_rd   = r_rd;
   assign bus.sdram_ba   = r_ba;
   assign bus.sdram_addr = r_addr;
   assign pass_cnt       = r_pass_cnt;
   assign fail           = r_fail;
   assign fail_bank      = r_fail_bank;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_jtsdram_sched.sv
// Randomized bench for jtsdram_sched: bank/controller models plus a round-robin reference.
module tb_jtsdram_sched;
   import jtsdram_pkg::*;

   localparam int AW     = 22;
   localparam int PASSES = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             go;
   logic             busy;
   logic             bank_start;
   logic [7:0]       pass_cnt;
   logic             fail;
   logic [NBANK-1:0] fail_bank;
   state_t           dbg_state;

   jtsdram_sched_if #(.AW(AW)) bus ();

   jtsdram_sched #(.PASSES(PASSES), .AW(AW)) dut (
      .rst         (rst),
      .clk         (clk),
      .go          (go),
      .busy        (busy),
      .bank_start  (bank_start),
      .pass_cnt    (pass_cnt),
      .fail        (fail),
      .fail_bank   (fail_bank),
      .o_dbg_state (dbg_state),
      .bus         (bus.master)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference model state
   logic [AW-1:0]    addr_tab [NBANK];
   logic [AW+1:0]    exp_q [$];
   int               ba_log [$];
   int               cnt [NBANK];
   int               m_last, owner, need;
   logic [NBANK-1:0] pending, prev_mask, snap;
   int               c_phase, c_wait;
   bit               c_same, same_mode, all_mode, c_stall, inject, go_chk;
   int               cyc_n = 0;
   int               pass_due, exp_pass, n_starts, grants;
   bit               exp_grant, chk_release, exp_fail;

   function automatic int rr_pick(input int last, input logic [NBANK-1:0] mask);
      for (int d = 1; d <= NBANK; d++)
         if (mask[(last + d) % NBANK]) return (last + d) % NBANK;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = 3;
      c_phase = 0;
      c_stall = 1'b0;
      exp_q.delete();
      pending = '0;
      for (int i = 0; i < NBANK; i++) cnt[i] = need;
      bus.bank_done = '1;
      bus.bank_rd   = '0;
      bus.bank_bad  = '0;
      bus.sdram_ack = 1'b0;
      bus.sdram_rdy = 1'b0;
      exp_grant = 1'b0;
      chk_release = 1'b0;
      go_chk = 1'b0;
      pass_due = -1;
   endtask

   task automatic complete(input int o);
      cnt[o]++;
      pending[o] = 1'b0;
      if (cnt[o] >= need) bus.bank_done[o] = 1'b1;
      if (&bus.bank_done) begin
         pass_due = cyc_n + 3;
         exp_pass++;
      end
   endtask

   task automatic chk_reset(input string pre);
      chk({pre, "_busy"},       32'(busy),           32'd0);
      chk({pre, "_bank_start"}, 32'(bank_start),     32'd0);
      chk({pre, "_sdram_rd"},   32'(bus.sdram_rd),   32'd0);
      chk({pre, "_sdram_ba"},   32'(bus.sdram_ba),   32'd0);
      chk({pre, "_sdram_addr"}, 32'(bus.sdram_addr), 32'd0);
      chk({pre, "_bank_ack"},   32'(bus.bank_ack),   32'd0);
      chk({pre, "_bank_rdy"},   32'(bus.bank_rdy),   32'd0);
      chk({pre, "_pass_cnt"},   32'(pass_cnt),       32'd0);
      chk({pre, "_fail"},       32'(fail),           32'd0);
      chk({pre, "_fail_bank"},  32'(fail_bank),      32'd0);
      chk({pre, "_state"},      32'(dbg_state),      32'(ST_IDLE));
   endtask

   // one clock of bank models + controller model, acting at the falling edge
   task automatic cyc(input bit go_in);
      bit rdy_now;
      int w;
      @(negedge clk);
      cyc_n++;
      rdy_now = 1'b0;
      go = go_in;
      bus.sdram_ack = 1'b0;
      bus.sdram_rdy = 1'b0;

      if (exp_grant)   chk("grant_latency", 32'(bus.sdram_rd), 32'd1);
      if (chk_release) chk("rd_release",    32'(bus.sdram_rd), 32'd0);
      exp_grant = 1'b0;
      chk_release = 1'b0;
      if (go_chk) begin
         chk("go_ignored_start", 32'(bank_start), 32'd0);
         chk("go_ignored_cnt",   32'(pass_cnt),   32'(exp_pass));
         go_chk = 1'b0;
      end
      if (cyc_n == pass_due - 1) begin
         chk("next_state",    32'(dbg_state), 32'(ST_NEXT));
         chk("pass_cnt_hold", 32'(pass_cnt),  32'(exp_pass - 1));
         snap = bus.bank_bad;
         exp_fail = exp_fail | (|snap);
      end
      if (cyc_n == pass_due) begin
         chk("pass_cnt",  32'(pass_cnt),  32'(exp_pass));
         chk("fail_bank", 32'(fail_bank), 32'(snap));
         chk("fail",      32'(fail),      32'(exp_fail));
         if (exp_pass == PASSES) chk("busy_fall", 32'(busy), 32'd0);
         else                    chk("restart",   32'(bank_start), 32'd1);
      end

      if (bank_start) begin
         n_starts++;
         for (int i = 0; i < NBANK; i++) cnt[i] = 0;
         pending = '0;
         bus.bank_done = '0;
         bus.bank_bad  = '0;
      end

      if (c_phase == 0 && bus.sdram_rd) begin
         w = rr_pick(m_last, prev_mask);
         if (w < 0) chk("grant_no_req", 32'(bus.sdram_rd), 32'd0);
         else begin
            exp_q.push_back({2'(w), addr_tab[w]});
            m_last = w;
            owner = w;
            pending[w] = 1'b1;
            grants++;
            ba_log.push_back(int'(bus.sdram_ba));
            chk("grant_ba_addr", 32'({bus.sdram_ba, bus.sdram_addr}), 32'(exp_q.pop_front()));
            c_phase = 1;
            c_same = same_mode ? 1'b1 : 1'($urandom_range(0, 1));
            c_wait = same_mode ? 0 : int'($urandom_range(0, 2));
         end
      end else if (c_phase == 1 && !c_stall) begin
         if (c_wait > 0) begin
            chk("rd_hold", 32'(bus.sdram_rd), 32'd1);
            c_wait--;
         end else begin
            bus.sdram_ack = 1'b1;
            if (c_same) bus.sdram_rdy = 1'b1;
            #1;
            chk("ack_route", 32'(bus.bank_ack), 32'd1 << owner);
            chk("rdy_route", 32'(bus.bank_rdy), c_same ? (32'd1 << owner) : 32'd0);
            if (c_same) begin
               complete(owner);
               rdy_now = 1'b1;
               c_phase = 0;
            end else begin
               c_phase = 2;
               c_wait = int'($urandom_range(0, 3));
            end
            chk_release = 1'b1;
         end
      end else if (c_phase == 2) begin
         if (c_wait > 0) c_wait--;
         else begin
            bus.sdram_rdy = 1'b1;
            #1;
            chk("rdy_route", 32'(bus.bank_rdy), 32'd1 << owner);
            chk("ack_quiet", 32'(bus.bank_ack), 32'd0);
            complete(owner);
            rdy_now = 1'b1;
            c_phase = 0;
            chk_release = 1'b1;
         end
      end

      for (int i = 0; i < NBANK; i++)
         bus.bank_rd[i] = !bus.bank_done[i] && !pending[i] && (cnt[i] < need) &&
                          (all_mode || $urandom_range(0, 2) != 0);
      prev_mask = bus.bank_rd;
      exp_grant = (c_phase == 0) && !rdy_now && (prev_mask != '0) && !bank_start;
      if (inject && exp_pass == 0 && grants == 3) bus.bank_bad = 4'b0100;
   endtask

   // driver tasks
   task automatic start_run(input int need_in, input bit all_in, input bit same_in, input bit inj_in);
      need = need_in;
      all_mode = all_in;
      same_mode = same_in;
      inject = inj_in;
      n_starts = 0;
      exp_pass = 0;
      exp_fail = 1'b0;
      grants = 0;
      pass_due = -1;
      ba_log.delete();
      for (int i = 0; i < NBANK; i++) begin
         cnt[i] = need;
         addr_tab[i] = AW'($urandom);
         bus.bank_addr[i*AW +: AW] = addr_tab[i];
      end
      cyc(1'b1);
      cyc(1'b0);
      chk("run_busy",      32'(busy),       32'd1);
      chk("run_start",     32'(bank_start), 32'd1);
      chk("run_clr_cnt",   32'(pass_cnt),   32'd0);
      chk("run_clr_fail",  32'(fail),       32'd0);
      chk("run_clr_fbank", 32'(fail_bank),  32'd0);
   endtask

   task automatic do_run(input int need_in, input bit all_in, input bit same_in, input bit inj_in);
      int k;
      bit g;
      bit go_sent;
      start_run(need_in, all_in, same_in, inj_in);
      k = 0;
      go_sent = 1'b0;
      while (busy && k < 3000) begin
         g = inject && grants == 2 && !go_sent;
         cyc(g);
         if (g) begin
            go_sent = 1'b1;
            go_chk = 1'b1;
         end
         k++;
      end
      if (k >= 3000) chk("run_timeout", 32'(busy), 32'd0);
      chk("start_pulses", 32'(n_starts), 32'(PASSES));
      chk("pass_cnt_end", 32'(pass_cnt), 32'(PASSES));
      chk("fail_end",     32'(fail),     32'(exp_fail));
   endtask

   initial begin
      int k;
      rst = 1'b1;
      go = 1'b0;
      need = 3;
      bus.bank_addr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      bus.sdram_ack = 1'b1;
      bus.sdram_rdy = 1'b1;
      #1;
      chk_reset("por");
      @(negedge clk);
      rst = 1'b0;
      bus.sdram_ack = 1'b0;
      bus.sdram_rdy = 1'b0;
      cyc(1'b0);

      // round-robin order from reset, every bank requesting, ack+rdy together
      do_run(2, 1'b1, 1'b1, 1'b0);
      chk("rr_count", 32'(ba_log.size()), 32'(PASSES * NBANK * 2));
      for (int i = 0; i < ba_log.size(); i++) chk("rr_order", 32'(ba_log[i]), 32'(i % NBANK));

      // random requests and controller timing, failure capture, ignored go
      do_run(3, 1'b0, 1'b0, 1'b1);

      // controller strobes while idle are not routed
      @(negedge clk);
      bus.sdram_ack = 1'b1;
      bus.sdram_rdy = 1'b1;
      #1;
      chk("idle_rdy_route", 32'(bus.bank_rdy), 32'd0);
      chk("idle_ack_route", 32'(bus.bank_ack), 32'd0);
      @(negedge clk);
      bus.sdram_ack = 1'b0;
      bus.sdram_rdy = 1'b0;
      chk("idle_rd", 32'(bus.sdram_rd), 32'd0);

      // reset with a request outstanding; fail/fail_bank clear on this go
      start_run(3, 1'b1, 1'b1, 1'b0);
      c_stall = 1'b1;
      k = 0;
      while (!bus.sdram_rd && k < 50) begin
         cyc(1'b0);
         k++;
      end
      chk("stall_grant", 32'(bus.sdram_rd), 32'd1);
      cyc(1'b0);
      rst = 1'b1;
      #1;
      chk_reset("mid_run");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      bus.sdram_ack = 1'b1;
      bus.sdram_rdy = 1'b1;
      #1;
      chk("post_rst_rdy", 32'(bus.bank_rdy), 32'd0);
      chk("post_rst_ack", 32'(bus.bank_ack), 32'd0);
      @(negedge clk);
      bus.sdram_ack = 1'b0;
      bus.sdram_rdy = 1'b0;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_rd",   32'(bus.sdram_rd), 32'd0);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
